// File: rtl/copia_memoria.sv
// copia_memoria: copy engine and single-port access arbiter in front of the
// register memory. Passes external requests through while idle and performs
// word-sequential block copies (read then write, per word) when started.
module copia_memoria #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_ads,
    input  logic [DATA_W-1:0] ext_din,
    output logic              ext_ready,
    output logic [DATA_W-1:0] ext_dout,
    output logic              ext_rvalid,
    output logic [ADDR_W-1:0] mem_ads,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W:0]   cnt;

    // State register, copy pointers/counter and external read-valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            cnt        <= '0;
            ext_rvalid <= 1'b0;
        end else begin
            state      <= state_nx;
            ext_rvalid <= ext_req && !ext_we && ext_ready;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q <= src;
                        dst_q <= dst;
                        cnt   <= len;
                    end
                end
                WRITE: begin
                    src_q <= src_q + 1'b1;
                    dst_q <= dst_q + 1'b1;
                    cnt   <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and memory port steering
    always_comb begin
        state_nx  = state;
        mem_ads   = ext_ads;
        mem_we    = 1'b0;
        mem_din   = ext_din;
        ext_ready = (state == IDLE) && !start && !rst;
        case (state)
            IDLE: begin
                mem_we = ext_req && ext_we && ext_ready;
                if (start) begin
                    state_nx = (len == '0) ? DONE : READ;
                end
            end
            READ: begin
                mem_ads  = src_q;
                state_nx = WRITE;
            end
            WRITE: begin
                mem_ads  = dst_q;
                mem_we   = 1'b1;
                mem_din  = mem_dout;
                // cnt still holds the pre-decrement value here
                state_nx = (cnt == (ADDR_W+1)'(1)) ? DONE : READ;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Reset blocks any memory write and parks the address at 0
        if (rst) begin
            mem_ads = '0;
            mem_we  = 1'b0;
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign ext_dout = mem_dout;

endmodule

// File: tb/tb_copia_memoria.sv
// Testbench for copia_memoria with a behavioural 32x64 register memory.
// Expected read data and done cycles are queued by stimulus and checked by
// an independent monitor.
module tb_copia_memoria;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_ads;
    logic [DATA_W-1:0] ext_din;
    logic              ext_ready;
    logic [DATA_W-1:0] ext_dout;
    logic              ext_rvalid;
    logic [ADDR_W-1:0] mem_ads;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    logic [DATA_W-1:0] mem [32];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_exp_cnt = 0;
    logic [DATA_W-1:0] rd_q[$];
    int done_q[$];

    copia_memoria #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .ext_req(ext_req), .ext_we(ext_we),
        .ext_ads(ext_ads), .ext_din(ext_din), .ext_ready(ext_ready),
        .ext_dout(ext_dout), .ext_rvalid(ext_rvalid), .mem_ads(mem_ads),
        .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory model: write on we=1, otherwise register dout (held during writes)
    always @(posedge clk) begin
        if (mem_we) mem[mem_ads] <= mem_din;
        else        mem_dout     <= mem[mem_ads];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares read data and done timing against queued expectations
    always @(negedge clk) begin
        if (ext_rvalid) begin
            if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else check("ext_dout", ext_dout, rd_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            if (done_q.size() == 0) check("done_unexpected", 1, 0);
            else check("done_cycle", DATA_W'(cyc), DATA_W'(done_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ext_write(input int a, input logic [DATA_W-1:0] d);
        ext_req = 1'b1; ext_we = 1'b1; ext_ads = ADDR_W'(a); ext_din = d;
        tick();
        ext_req = 1'b0; ext_we = 1'b0;
    endtask

    task automatic ext_read(input int a, input logic [DATA_W-1:0] exp);
        ext_req = 1'b1; ext_we = 1'b0; ext_ads = ADDR_W'(a);
        rd_q.push_back(exp);
        tick();
        ext_req = 1'b0;
    endtask

    task automatic issue_start(input int s, input int d, input int l, input bit expect_done);
        start = 1'b1; src = ADDR_W'(s); dst = ADDR_W'(d); len = (ADDR_W+1)'(l);
        tick();
        start = 1'b0;
        if (expect_done) begin
            done_q.push_back(cyc + 2*l);
            done_exp_cnt++;
        end
    endtask

    task automatic wait_done(output int bcycles, output bit we_seen);
        bit got = 0;
        bit rdy_bad = 0;
        bcycles = 0;
        we_seen = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (busy) bcycles++;
            if (mem_we) we_seen = 1;
            if (ext_ready) rdy_bad = 1;
            if (done) got = 1;
        end
        tick();
        check("done_seen", DATA_W'(got), 1);
        check("ready_low_in_copy", DATA_W'(rdy_bad), 0);
    endtask

    initial begin
        int bc;
        bit ws;
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        ext_req = 1'b1; ext_we = 1'b1; ext_ads = 5'd9; ext_din = 64'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", DATA_W'(busy), 0);
        check("rst_done", DATA_W'(done), 0);
        check("rst_rvalid", DATA_W'(ext_rvalid), 0);
        check("rst_mem_we", DATA_W'(mem_we), 0);
        check("rst_mem_ads", DATA_W'(mem_ads), 0);
        check("rst_ready", DATA_W'(ext_ready), 0);
        ext_req = 1'b0; ext_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("ready_after_rst", DATA_W'(ext_ready), 1);
        check("ads_passthrough", DATA_W'(mem_ads), 9);

        // Write then read
        ext_write(7, 64'hDEAD_BEEF_0123_4567);
        ext_read(7, 64'hDEAD_BEEF_0123_4567);
        tick();

        // Single-word copy
        ext_write(16, 64'd45);
        issue_start(16, 3, 1, 1);
        wait_done(bc, ws);
        check("busy_cycles_len1", DATA_W'(bc), 3);
        ext_read(3, 64'd45);
        tick();

        // Wrapping block copy
        for (int i = 0; i < 32; i++) ext_write(i, 64'(i + 100));
        issue_start(30, 10, 4, 1);
        wait_done(bc, ws);
        ext_read(10, 64'd130);
        ext_read(11, 64'd131);
        ext_read(12, 64'd100);
        ext_read(13, 64'd101);
        tick();

        // Overlapping forward copy
        ext_write(0, 64'd5);
        issue_start(0, 1, 3, 1);
        wait_done(bc, ws);
        for (int i = 1; i <= 3; i++) ext_read(i, 64'd5);
        tick();

        // Zero length
        issue_start(4, 8, 0, 1);
        wait_done(bc, ws);
        check("len0_busy_cycles", DATA_W'(bc), 1);
        check("len0_no_we", DATA_W'(ws), 0);

        // start and ext write in the same cycle
        ext_write(29, 64'hAAAA);
        ext_req = 1'b1; ext_we = 1'b1; ext_ads = 5'd29; ext_din = 64'hBBBB;
        start = 1'b1; src = 5'd5; dst = 5'd25; len = 6'd1;
        #1;
        check("arb_ready_low", DATA_W'(ext_ready), 0);
        tick();
        start = 1'b0; ext_req = 1'b0; ext_we = 1'b0;
        done_q.push_back(cyc + 2);
        done_exp_cnt++;
        wait_done(bc, ws);
        ext_read(29, 64'hAAAA);
        ext_read(25, 64'd105);
        tick();

        // start during a copy is ignored
        issue_start(6, 26, 2, 1);
        start = 1'b1; src = 5'd0; dst = 5'd28; len = 6'd1;
        tick();
        start = 1'b0;
        wait_done(bc, ws);
        repeat (6) tick();
        check("done_count", DATA_W'(done_cnt), DATA_W'(done_exp_cnt));
        ext_read(26, 64'd106);
        ext_read(27, 64'd107);
        ext_read(28, 64'd128);
        tick();

        // Reset mid-copy after the third WRITE
        ext_write(0, 64'h1000);
        ext_write(1, 64'h1001);
        ext_write(2, 64'h1002);
        issue_start(0, 16, 8, 0);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("abort_busy", DATA_W'(busy), 0);
        check("abort_done", DATA_W'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_ready", DATA_W'(ext_ready), 1);
        ext_read(16, 64'h1000);
        ext_read(17, 64'h1001);
        ext_read(18, 64'h1002);
        for (int i = 19; i <= 23; i++) ext_read(i, 64'(i + 100));
        repeat (4) tick();
        check("abort_done_count", DATA_W'(done_cnt), DATA_W'(done_exp_cnt));
        check("rd_q_drained", DATA_W'(rd_q.size()), 0);
        check("done_q_drained", DATA_W'(done_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/copia_memoria.md
# copia_memoria

DMA-style copy engine and access port sitting directly upstream of the 32×64 register memory. When idle it passes single external read/write requests straight through to the memory. On `start` it takes exclusive ownership of the memory port and copies `len` consecutive 64-bit words from `src` to `dst`, then pulses `done`. It is the only block that drives the memory's `ads`/`we`/`din`.

## Interface
- `ADDR_W`, 5, memory address width (32 words).
- `DATA_W`, 64, word width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  copy request; sampled only in IDLE.
- `src`  in  ADDR_W  first source address, captured on accepted `start`.
- `dst`  in  ADDR_W  first destination address, captured on accepted `start`.
- `len`  in  ADDR_W+1  word count, 0..32, captured on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the `done` cycle, inclusive.
- `done`  out  1  one-cycle pulse when a copy completes.
- `ext_req`  in  1  external single-word access request.
- `ext_we`  in  1  1 = write, 0 = read.
- `ext_ads`  in  ADDR_W  external address.
- `ext_din`  in  DATA_W  external write data.
- `ext_ready`  out  1  combinational: `state==IDLE && !start && !rst`. A request is accepted when `ext_req && ext_ready`.
- `ext_dout`  out  DATA_W  equals `mem_dout`; valid while `ext_rvalid`.
- `ext_rvalid`  out  1  high exactly one cycle after an accepted external read.
- `mem_ads`  out  ADDR_W  to memory `ads`.
- `mem_we`  out  1  to memory `we`.
- `mem_din`  out  DATA_W  to memory `din`.
- `mem_dout`  in  DATA_W  from memory `dout`. The memory registers this output on a `we=0` cycle and holds it on `we=1` cycles.

## Operation
- **FSM states:** IDLE, READ, WRITE, DONE.
- **IDLE**
  - `mem_ads=ext_ads`, `mem_din=ext_din`, `mem_we=ext_req&&ext_we&&ext_ready`.
  - On `start`: latch `src_q`, `dst_q`, `cnt=len`.
  - If `len==0`, go to DONE; otherwise go to READ.
  - `start` has priority over `ext_req` in the same cycle; the external request is not accepted.
- **READ:** `mem_ads=src_q`, `mem_we=0`. Next state is WRITE.
- **WRITE**
  - `mem_ads=dst_q`, `mem_we=1`, `mem_din=mem_dout`.
  - Then `src_q++`, `dst_q++` (both mod 32), `cnt--`.
  - If the new `cnt==0`, go to DONE; otherwise go to READ.
- **DONE:** `done=1`, `mem_we=0`. Next state is IDLE.
- **`start` while not IDLE:** ignored; not queued.
- **Address wrap:** addresses wrap 31→0. `len=32` copies the whole memory.
- **Overlap:** word-sequential ascending semantics. Each read sees all earlier writes of the same copy, so `dst=src+1` replicates `mem[src]` forward.
- **External write:** memory is written on the accept edge.
- **External read:** data appears on `mem_dout` the next cycle, flagged by `ext_rvalid`. A copy starting in that same cycle does not disturb it, because READ updates `mem_dout` only at the end of the cycle.
- **Reset:**
  - FSM goes to IDLE; `busy=0`, `done=0`, `ext_rvalid=0`; counters and addresses are cleared to 0.
  - While `rst` is high, `mem_we=0` and `ext_ready=0`.
  - Reset mid-copy aborts immediately. Words already written stay written; no further writes occur; no `done`.

## Timing
- **Reset values:** `busy=0`, `done=0`, `ext_rvalid=0`, `mem_we=0`, `mem_ads=0` (`ext_ads` passthrough after reset), `ext_ready=1` once `rst` is low and `start` is low.
- **Copy latency:** `start` accepted at edge T0. The first READ is the cycle after T0, and each word takes 2 cycles (READ, WRITE).
  - `done` is high in cycle 2·len+1 after T0; IDLE resumes the next cycle.
  - `len=0`: `done` is high the cycle after T0.
- **Throughput:** one word per 2 cycles.
- **External accesses:**
  - Write: 0 cycles of latency into memory.
  - Read: `ext_rvalid` rises 1 cycle after acceptance.
  - Back-to-back external requests are allowed every cycle.
- `ext_ready` is low for the whole copy, from the accept cycle through the DONE cycle.

## Test plan
- **Write then read:** external write `ads=7`, `din=64'hDEAD_BEEF_0123_4567`, then read `ads=7` → `ext_rvalid` one cycle later with `ext_dout=64'hDEAD_BEEF_0123_4567`.
- **Single-word copy:** preload `mem[16]=45`, start `src=16`, `dst=3`, `len=1` → `done` 3 cycles after accept, `busy` high 3 cycles, readback `mem[3]=45`.
- **Wrapping block copy:** fill `mem[i]=i+100`, start `src=30`, `dst=10`, `len=4` → `mem[10..13]=130,131,100,101`, `done` at cycle 9.
- **Overlap and zero length:**
  - `mem[0]=5`, start `src=0`, `dst=1`, `len=3` → `mem[1..3]=5`.
  - `len=0` → `done` next cycle, no `mem_we` pulse.
- **Arbitration:**
  - `start` and `ext_req` (write) in the same cycle → external request not accepted, `ext_ready=0`, target word unchanged.
  - `start` asserted during a copy is ignored; exactly one `done` is produced.
- **Reset mid-copy:** `len=8` from `src=0` to `dst=16`, assert `rst` after the 3rd WRITE →
  - `mem[16..18]` copied, `mem[19..23]` unchanged.
  - No `done`; `busy=0` the cycle after reset.
  - `ext_ready=1` after `rst` is released.
